vc_out_arbiter: RTL and testbench
=================================

# vc_out_arbiter

Parametrised virtual-channel output stage for a router output port. Each cycle it selects one of NUM_VC input virtual channels by round-robin arbitration, gated by per-VC downstream credit counters. It forwards the winning flit to the link through a registered output, with an optional packet-lock (wormhole) mode. It sits between the per-VC input buffers of an output port and the inter-router link. It replaces the fixed 6-way one-hot select with arbitration, flow control and a pipeline register.

## Interface
Parameters:
- NUM_VC, 6: number of virtual channels (≥2).
- DW, 32: flit data width.
- CREDIT_DEPTH, 4: downstream buffer depth per VC, in flits (≥1).
- LOCK_PKT, 0: 1 = hold the grant on a VC from head flit until tail flit; 0 = arbitrate per flit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  NUM_VC*DW  flit of VC i on bits [i*DW +: DW].
- valid_in  input  NUM_VC  VC i has a flit available.
- tail_in  input  NUM_VC  flit on VC i is a tail flit (single-flit packet = tail).
- ready_out  output  NUM_VC  one-hot (or zero) pop strobe to VC i input buffer; combinational.
- credit_in  input  1  one credit returned by downstream this cycle.
- credit_vc  input  $clog2(NUM_VC)  VC index of the returned credit.
- data_out  output  DW  registered flit to link.
- valid_out  output  1  registered flit valid.
- vc_out  output  $clog2(NUM_VC)  registered VC index of data_out.
- credit_err  output  1  sticky error flag.

## Operation
- Eligibility: VC i is eligible when valid_in[i]=1 and credit[i]>0. When LOCK_PKT=1 and the lock is active, only the locked VC may be eligible.
- Arbitration: round-robin, pointer ptr. The first eligible VC scanning ptr, ptr+1, …, wrapping at NUM_VC, wins. With no eligible VC, there is no grant and ready_out=0.
- After a grant to VC g, ptr ← (g+1) mod NUM_VC. ptr is unchanged on idle cycles.
- Grant effects, same cycle: ready_out[g]=1. On the edge: data_out←data_in[g], vc_out←g, valid_out←1, and credit[g] is decremented.
- Idle cycle: on the edge, valid_out←0. data_out and vc_out hold their previous values.
- Credit counters: width $clog2(CREDIT_DEPTH+1), reset to CREDIT_DEPTH.
  - Return (credit_in=1) on VC v increments credit[v].
  - Return and grant on the same VC in the same cycle leave the counter unchanged.
  - A return that would exceed CREDIT_DEPTH saturates the counter and sets credit_err.
  - credit_vc ≥ NUM_VC with credit_in=1 is ignored and sets credit_err.
- Lock (LOCK_PKT=1):
  - Granting a non-tail flit sets lock on VC g.
  - Granting a tail flit clears the lock.
  - While locked, other VCs are never granted, even if the locked VC is stalled on credit or valid.
  - ptr still advances per the grant rule.
- LOCK_PKT=0: tail_in is ignored.

## Timing
- Reset values: valid_out=0, data_out=0, vc_out=0, credit_err=0, all credit[i]=CREDIT_DEPTH, ptr=0, lock cleared.
- ready_out=0 whenever rst=1.
- Latency: a flit granted in cycle t appears on data_out/valid_out in cycle t+1. Sustained throughput is 1 flit/cycle.
- ready_out[i] depends combinationally on valid_in, credit state, ptr and lock. The input buffer pops on the edge where ready_out[i]=1.
- A credit returned in cycle t is usable for arbitration in cycle t+1.
- A VC with credit=1 that is granted in t is ineligible in t+1 unless a credit for it also arrived in t.
- Reset mid-packet: lock cleared, credits restored, and any in-flight output flit dropped (valid_out=0 the cycle after rst).
- credit_err stays at 1 until rst.

## Test plan
- Fairness: NUM_VC=6, all valid_in=1, credits ample, returned every cycle → grants VC0,1,2,3,4,5,0,… one per cycle. vc_out follows the same sequence one cycle later, with valid_out=1 continuously.
- Credit exhaustion: CREDIT_DEPTH=4, only VC2 valid, no returns → exactly 4 flits sent on consecutive cycles, then ready_out=0 and valid_out=0. A single credit_in on VC2 → exactly 1 more flit, sent the next cycle.
- Simultaneous return and grant: VC1 credit=2, grant VC1 with credit_in=1 and credit_vc=1 in the same cycle → credit stays 2, credit_err=0.
- Packet lock: LOCK_PKT=1, VC3 sends a 3-flit packet (tail on flit 3) while VC0 is valid and VC3 valid drops for 2 cycles mid-packet → VC0 is never granted until VC3's tail is sent. VC0 is granted the cycle after the tail.
- Error: returning a credit on VC4 while credit[4]=CREDIT_DEPTH → counter stays 4 and credit_err=1 from the next cycle until rst.
- Reset mid-operation: assert rst during streaming → valid_out=0, data_out=0, vc_out=0 the next cycle. After release, credits=CREDIT_DEPTH and the first grant is the lowest eligible index from 0.

Source files
------------

// File: rtl/vc_out_arbiter.sv
// Virtual-channel output stage for one router output port.
// Round-robin arbitration across NUM_VC input VCs, gated by per-VC
// downstream credit counters, with an optional wormhole packet lock.
// The winning flit is registered onto the link one cycle after grant.
module vc_out_arbiter #(
  parameter int NUM_VC       = 6,
  parameter int DW           = 32,
  parameter int CREDIT_DEPTH = 4,
  parameter int LOCK_PKT     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_VC*DW-1:0]      data_in,
  input  logic [NUM_VC-1:0]         valid_in,
  input  logic [NUM_VC-1:0]         tail_in,
  output logic [NUM_VC-1:0]         ready_out,
  input  logic                      credit_in,
  input  logic [$clog2(NUM_VC)-1:0] credit_vc,
  output logic [DW-1:0]             data_out,
  output logic                      valid_out,
  output logic [$clog2(NUM_VC)-1:0] vc_out,
  output logic                      credit_err
);

  localparam int VCW = $clog2(NUM_VC);
  localparam int CW  = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CW-1:0]  CRED_MAX   = CW'(CREDIT_DEPTH);
  localparam logic [CW-1:0]  CRED_ONE   = CW'(1);
  localparam logic [CW-1:0]  CRED_ZERO  = CW'(0);
  localparam logic [VCW-1:0] LAST_VC    = VCW'(NUM_VC - 1);
  localparam logic [VCW-1:0] VC_ZERO    = VCW'(0);
  localparam logic [VCW-1:0] VC_ONE     = VCW'(1);
  localparam logic [VCW:0]   NUM_VC_EXT = (VCW + 1)'(NUM_VC);

  // State
  logic [CW-1:0]  credit_q [NUM_VC];
  logic [CW-1:0]  credit_d [NUM_VC];
  logic [VCW-1:0] ptr_q, ptr_d;
  logic           lock_q, lock_d;
  logic [VCW-1:0] lock_vc_q, lock_vc_d;
  logic           err_q, err_d;
  logic [DW-1:0]  data_q;
  logic           valid_q;
  logic [VCW-1:0] vc_q;

  // Combinational
  logic [DW-1:0]       flit_s [NUM_VC];
  logic [NUM_VC-1:0]   elig_s;
  logic [2*NUM_VC-1:0] rot_s;
  logic [VCW:0]        off_s;
  logic [VCW:0]        sum_s;
  logic                gnt_vld_s;
  logic [VCW-1:0]      gnt_idx_s;
  logic                ret_ok_s;
  logic [NUM_VC-1:0]   inc_s;
  logic [NUM_VC-1:0]   dec_s;

  // Split the packed input bus into per-VC flits and compute eligibility.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      flit_s[i] = data_in[i*DW +: DW];
      elig_s[i] = valid_in[i] && (credit_q[i] != CRED_ZERO) &&
                  (!lock_q || (lock_vc_q == VCW'(i)));
    end
  end

  // Round-robin pick: rotate eligibility so ptr lands at bit 0, take lowest set bit.
  always_comb begin
    rot_s     = {elig_s, elig_s} >> ptr_q;
    gnt_vld_s = |rot_s[NUM_VC-1:0];
    off_s     = {(VCW+1){1'b0}};
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = (VCW + 1)'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, ptr_q} + off_s;
    if (sum_s >= NUM_VC_EXT) begin
      sum_s = sum_s - NUM_VC_EXT;
    end else begin
      sum_s = sum_s;
    end
    gnt_idx_s = sum_s[VCW-1:0];
  end

  // Pop strobe to the winning input buffer; suppressed while in reset.
  always_comb begin
    ready_out = {NUM_VC{1'b0}};
    if (gnt_vld_s && !rst) begin
      ready_out[gnt_idx_s] = 1'b1;
    end else begin
      ready_out = {NUM_VC{1'b0}};
    end
  end

  // Credit counter next state: a return and a grant on the same VC cancel out.
  always_comb begin
    ret_ok_s = credit_in && ({1'b0, credit_vc} < NUM_VC_EXT);
    err_d    = err_q | (credit_in & ~ret_ok_s);
    for (int i = 0; i < NUM_VC; i++) begin
      inc_s[i]    = ret_ok_s && (credit_vc == VCW'(i));
      dec_s[i]    = gnt_vld_s && (gnt_idx_s == VCW'(i));
      credit_d[i] = credit_q[i];
      case ({inc_s[i], dec_s[i]})
        2'b10: begin
          if (credit_q[i] == CRED_MAX) begin
            err_d = 1'b1;
          end else begin
            credit_d[i] = credit_q[i] + CRED_ONE;
          end
        end
        2'b01:   credit_d[i] = credit_q[i] - CRED_ONE;
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  // Pointer and packet-lock next state; both only move on a grant.
  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    if (gnt_vld_s) begin
      ptr_d     = (gnt_idx_s == LAST_VC) ? VC_ZERO : (gnt_idx_s + VC_ONE);
      lock_d    = (LOCK_PKT != 0) ? ~tail_in[gnt_idx_s] : 1'b0;
      lock_vc_d = gnt_idx_s;
    end else begin
      ptr_d     = ptr_q;
      lock_d    = lock_q;
      lock_vc_d = lock_vc_q;
    end
  end

  // Arbitration state: credits, round-robin pointer, lock and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        credit_q[i] <= CRED_MAX;
      end
      ptr_q     <= VC_ZERO;
      lock_q    <= 1'b0;
      lock_vc_q <= VC_ZERO;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        credit_q[i] <= credit_d[i];
      end
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
      err_q     <= err_d;
    end
  end

  // Link output register: load on grant, otherwise drop valid and hold payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= {DW{1'b0}};
      valid_q <= 1'b0;
      vc_q    <= VC_ZERO;
    end else if (gnt_vld_s) begin
      data_q  <= flit_s[gnt_idx_s];
      valid_q <= 1'b1;
      vc_q    <= gnt_idx_s;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign vc_out     = vc_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_vc_out_arbiter.sv
// Self-checking bench for vc_out_arbiter: a per-flit instance and a
// packet-lock instance share stimulus; each is compared against a
// behavioural model of credits, round-robin order and lock rules.
module tb_vc_out_arbiter;

  localparam int NV = 6;
  localparam int DW = 32;
  localparam int CD = 4;

  logic              clk;
  logic              rst;
  logic [NV*DW-1:0]  data_in;
  logic [NV-1:0]     valid_in;
  logic [NV-1:0]     tail_in;
  logic              credit_in;
  logic [2:0]        credit_vc;
  logic [NV-1:0]     rdy  [2];
  logic [DW-1:0]     dout [2];
  logic              vout [2];
  logic [2:0]        vco  [2];
  logic              err  [2];

  int n_cmp;
  int n_mis;

  // Reference model state, index 0 = per-flit, 1 = packet lock
  int          cr    [2][NV];
  int          mptr  [2];
  bit          mlk   [2];
  int          mlkvc [2];
  bit          merr  [2];
  bit          mvalid[2];
  logic [31:0] mdata [2];
  int          mvc   [2];
  int          mgnt  [2];

  vc_out_arbiter #(.NUM_VC(NV), .DW(DW), .CREDIT_DEPTH(CD), .LOCK_PKT(0)) u_dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .tail_in(tail_in),
    .ready_out(rdy[0]), .credit_in(credit_in), .credit_vc(credit_vc),
    .data_out(dout[0]), .valid_out(vout[0]), .vc_out(vco[0]), .credit_err(err[0]));

  vc_out_arbiter #(.NUM_VC(NV), .DW(DW), .CREDIT_DEPTH(CD), .LOCK_PKT(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .tail_in(tail_in),
    .ready_out(rdy[1]), .credit_in(credit_in), .credit_vc(credit_vc),
    .data_out(dout[1]), .valid_out(vout[1]), .vc_out(vco[1]), .credit_err(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NV-1:0] onehot(input int idx);
    logic [NV-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic model_reset(input int m);
    for (int i = 0; i < NV; i++) cr[m][i] = CD;
    mptr[m] = 0; mlk[m] = 0; mlkvc[m] = 0; merr[m] = 0;
    mvalid[m] = 0; mdata[m] = '0; mvc[m] = 0;
  endtask

  // First VC at or after the pointer (cyclically) with a flit and a credit,
  // restricted to the locked VC while a packet is in progress.
  function automatic int model_grant(input int m);
    for (int k = 0; k < NV; k++) begin
      int v;
      v = (mptr[m] + k) % NV;
      if (valid_in[v] && cr[m][v] > 0 && (!mlk[m] || mlkvc[m] == v)) return v;
    end
    return -1;
  endfunction

  task automatic model_update(input int m);
    int g;
    int v;
    if (rst) begin
      model_reset(m);
    end else begin
      g = mgnt[m];
      if (g >= 0) begin
        mvalid[m] = 1;
        mdata[m]  = data_in[g*DW +: DW];
        mvc[m]    = g;
        cr[m][g]  = cr[m][g] - 1;
        mptr[m]   = (g + 1) % NV;
        if (m == 1) begin
          mlk[m]   = !tail_in[g];
          mlkvc[m] = g;
        end
      end else begin
        mvalid[m] = 0;
      end
      if (credit_in) begin
        v = int'(credit_vc);
        if (v >= NV) merr[m] = 1;
        else if (cr[m][v] == CD) merr[m] = 1;
        else cr[m][v] = cr[m][v] + 1;
      end
    end
  endtask

  task automatic drive(input bit r, input logic [NV-1:0] v, input logic [NV-1:0] t,
                       input bit ci, input logic [2:0] cv);
    rst = r; valid_in = v; tail_in = t; credit_in = ci; credit_vc = cv;
    for (int i = 0; i < NV; i++) data_in[i*DW +: DW] = $urandom;
  endtask

  // One clock: check pop strobes before the edge, registered outputs after.
  task automatic step();
    #1;
    for (int m = 0; m < 2; m++) begin
      mgnt[m] = rst ? -1 : model_grant(m);
      check_val($sformatf("ready%0d", m), rdy[m], onehot(mgnt[m]));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_update(m);
    #1;
    for (int m = 0; m < 2; m++) begin
      check_val($sformatf("valid_out%0d", m), vout[m], mvalid[m]);
      check_val($sformatf("data_out%0d", m), dout[m], mdata[m]);
      check_val($sformatf("vc_out%0d", m), vco[m], mvc[m]);
      check_val($sformatf("credit_err%0d", m), err[m], merr[m]);
    end
    @(negedge clk);
  endtask

  localparam logic [NV-1:0] ALL = 6'h3F;
  localparam logic [NV-1:0] NONE = 6'h00;

  logic [NV-1:0] lk_valid [6];
  logic [NV-1:0] lk_tail  [6];
  logic [NV-1:0] lk_exp   [6];

  initial begin
    n_cmp = 0; n_mis = 0;
    model_reset(0); model_reset(1);
    mgnt[0] = -1; mgnt[1] = -1;
    drive(1'b1, NONE, NONE, 1'b0, 3'd0);
    @(negedge clk);
    step(); step();

    // Fairness: everything valid, credit of last winner returned each cycle
    for (int t = 0; t < 13; t++) begin
      drive(1'b0, ALL, ALL, t > 0, 3'((t + 5) % NV));
      #1 check_val("fair_ready", rdy[0], onehot(t % NV));
      step();
    end

    // Credit exhaustion on VC2, then one returned credit
    drive(1'b1, NONE, NONE, 1'b0, 3'd0); step();
    for (int t = 0; t < 6; t++) begin
      drive(1'b0, 6'h04, ALL, 1'b0, 3'd0);
      #1 check_val("exh_ready", rdy[0], (t < 4) ? 6'h04 : 6'h00);
      step();
    end
    check_val("exh_valid_out", vout[0], 1'b0);
    drive(1'b0, 6'h04, ALL, 1'b1, 3'd2); #1 check_val("exh_ret_ready", rdy[0], 6'h00); step();
    drive(1'b0, 6'h04, ALL, 1'b0, 3'd0); #1 check_val("exh_extra_ready", rdy[0], 6'h04); step();
    drive(1'b0, 6'h04, ALL, 1'b0, 3'd0); #1 check_val("exh_done_ready", rdy[0], 6'h00); step();

    // Return and grant on VC1 in the same cycle leaves credit at 2
    drive(1'b1, NONE, NONE, 1'b0, 3'd0); step();
    drive(1'b0, 6'h02, ALL, 1'b0, 3'd0); step(); step();
    drive(1'b0, 6'h02, ALL, 1'b1, 3'd1); step();
    check_val("simul_err", err[0], 1'b0);
    drive(1'b0, 6'h02, ALL, 1'b0, 3'd0);
    for (int t = 0; t < 3; t++) begin
      #1 check_val("simul_ready", rdy[0], (t < 2) ? 6'h02 : 6'h00);
      step();
    end

    // Packet lock: VC3 three-flit packet with a two-cycle gap
    lk_valid = '{6'h08, 6'h09, 6'h01, 6'h01, 6'h09, 6'h01};
    lk_tail  = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00};
    lk_exp   = '{6'h08, 6'h08, 6'h00, 6'h00, 6'h08, 6'h01};
    drive(1'b1, NONE, NONE, 1'b0, 3'd0); step();
    for (int t = 0; t < 6; t++) begin
      drive(1'b0, lk_valid[t], lk_tail[t], 1'b0, 3'd0);
      #1 check_val("lock_ready", rdy[1], lk_exp[t]);
      step();
    end

    // Credit overflow and out-of-range VC both set the sticky error
    drive(1'b1, NONE, NONE, 1'b0, 3'd0); step();
    drive(1'b0, NONE, NONE, 1'b1, 3'd4); step();
    check_val("ovf_err", err[0], 1'b1);
    drive(1'b0, NONE, NONE, 1'b0, 3'd0); step(); step(); step();
    check_val("ovf_err_sticky", err[0], 1'b1);
    drive(1'b1, NONE, NONE, 1'b0, 3'd0); step();
    check_val("err_cleared", err[0], 1'b0);
    drive(1'b0, NONE, NONE, 1'b1, 3'd6); step();
    check_val("range_err", err[0], 1'b1);

    // Reset mid-stream drops the in-flight flit and restarts from VC0
    drive(1'b1, NONE, NONE, 1'b0, 3'd0); step();
    for (int t = 0; t < 4; t++) begin
      drive(1'b0, ALL, 6'h00, 1'b0, 3'd0); step();
    end
    drive(1'b1, ALL, 6'h00, 1'b0, 3'd0); step();
    check_val("rst_valid_out", vout[0], 1'b0);
    check_val("rst_data_out", dout[0], 32'h0);
    check_val("rst_vc_out", vco[1], 3'd0);
    drive(1'b0, 6'h3E, ALL, 1'b0, 3'd0);
    #1 check_val("rst_first_ready", rdy[1], 6'h02);
    step();

    // Randomised traffic with occasional resets and bad credit returns
    for (int n = 0; n < 800; n++) begin
      logic [2:0] cv;
      cv = ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      drive($urandom_range(0, 59) == 0, NV'($urandom), NV'($urandom),
            $urandom_range(0, 2) != 0, cv);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
